// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Parametrised inter-stage pipeline register with valid/ready
//            handshake, 2-entry skid buffer (registered up_ready), flush with
//            bubble insertion and saturating stall/drop counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int DATA_W     = 35,
  parameter int CTRL_W     = 13,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] C_CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                up_ready_q, up_ready_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic                acc;
  logic                pop;
  logic [1:0]          held;
  logic [1:0]          drop_inc;
  logic [SUM_W-1:0]    stall_sum;
  logic [SUM_W-1:0]    drop_sum;

  assign dn_valid  = (state_q != ST_EMPTY);
  assign acc       = up_valid & up_ready_q;
  assign pop       = dn_valid & dn_ready;
  assign up_ready  = up_ready_q;
  assign dn_data   = main_data_q;
  // Empty slots present as bubbles: control forced to the no-op encoding.
  assign dn_ctrl   = dn_valid ? main_ctrl_q : '0;
  assign stall_cnt = stall_q;
  assign drop_cnt  = drop_q;

  // Entries squashed by a flush: held ones not leaving this cycle plus any accept.
  always_comb begin
    held = 2'd0;
    case (state_q)
      ST_ONE:  held = 2'd1;
      ST_FULL: held = 2'd2;
      default: held = 2'd0;
    endcase
    drop_inc = held - {1'b0, pop} + {1'b0, acc};
  end

  // Occupancy next-state and slot loading; flush overrides all transitions.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d     = ST_ONE;
            main_data_d = up_data;
            main_ctrl_d = up_ctrl;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            main_data_d = up_data;
            main_ctrl_d = up_ctrl;
          end else if (acc) begin
            state_d     = ST_FULL;
            skid_data_d = up_data;
            skid_ctrl_d = up_ctrl;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    up_ready_d = (state_d != ST_FULL);
  end

  // Saturating counter updates; clear beats increment.
  always_comb begin
    stall_sum = {2'b00, stall_q} + {{(SUM_W-1){1'b0}}, (dn_valid & ~dn_ready)};
    drop_sum  = {2'b00, drop_q} + {{CNT_W{1'b0}}, (flush ? drop_inc : 2'd0)};
    if (cnt_clr) begin
      stall_d = '0;
      drop_d  = '0;
    end else begin
      stall_d = (stall_sum > C_CNT_MAX) ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
      drop_d  = (drop_sum  > C_CNT_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  // State, slot and registered-ready storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      up_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      up_ready_q  <= up_ready_d;
    end
  end

  // Performance counter storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Directed self-checking bench for pipe_stage_skid. A second
//            instance (CLEAR_DATA=0, CNT_W=4) shares the stimulus to cover
//            data retention on flush and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        cnt_clr;
  logic        up_valid;
  logic [34:0] up_data;
  logic [12:0] up_ctrl;
  logic        dn_ready;

  logic        up_ready,  up_ready2;
  logic        dn_valid,  dn_valid2;
  logic [34:0] dn_data,   dn_data2;
  logic [12:0] dn_ctrl,   dn_ctrl2;
  logic [15:0] stall_cnt, drop_cnt;
  logic [3:0]  stall_cnt2, drop_cnt2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(35), .CTRL_W(13), .CLEAR_DATA(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .cnt_clr(cnt_clr),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_ctrl(up_ctrl),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_ctrl(dn_ctrl),
    .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );

  pipe_stage_skid #(.DATA_W(35), .CTRL_W(13), .CLEAR_DATA(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .cnt_clr(cnt_clr),
    .up_valid(up_valid), .up_ready(up_ready2), .up_data(up_data), .up_ctrl(up_ctrl),
    .dn_valid(dn_valid2), .dn_ready(dn_ready), .dn_data(dn_data2), .dn_ctrl(dn_ctrl2),
    .stall_cnt(stall_cnt2), .drop_cnt(drop_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
    up_valid = 1'b1;
    up_data  = 35'h1_2345_6789;
    up_ctrl  = 13'h0A5;
    dn_ready = 1'b1;

    // Reset held: nothing accepted, bubble outputs.
    repeat (3) tick();
    chk("rst_up_ready", up_ready, 1);
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_dn_ctrl",  dn_ctrl, 0);
    chk("rst_dn_data",  dn_data, 0);
    chk("rst_stall",    stall_cnt, 0);
    chk("rst_drop",     drop_cnt, 0);
    reset = 1'b1;

    // Pass-through: first accept at first edge with reset released.
    tick();
    chk("pt_valid", dn_valid, 1);
    chk("pt_data",  dn_data, 64'h1_2345_6789);
    chk("pt_ctrl",  dn_ctrl, 64'h0A5);
    up_valid = 1'b0;
    tick();
    chk("pt_drain_valid", dn_valid, 0);
    chk("pt_drain_ctrl",  dn_ctrl, 0);

    // Backpressure into the skid slot.
    up_valid = 1'b1; up_data = 35'd1; up_ctrl = 13'd1;
    tick();                                   // accept 1
    chk("bp_e1", dn_data, 1);
    dn_ready = 1'b0; up_data = 35'd2; up_ctrl = 13'd2;
    tick();                                   // accept 2 -> FULL
    chk("bp_full_ready", up_ready, 0);
    chk("bp_full_head",  dn_data, 1);
    up_data = 35'd3; up_ctrl = 13'd3;
    tick();
    chk("bp_hold_ready", up_ready, 0);
    chk("bp_hold_head",  dn_ctrl, 1);
    tick();
    dn_ready = 1'b1;
    tick();                                   // pop 1
    chk("bp_o2_data",  dn_data, 2);
    chk("bp_o2_ready", up_ready, 1);
    tick();                                   // pop 2, accept 3
    chk("bp_o3_data", dn_data, 3);
    chk("bp_o3_ctrl", dn_ctrl, 3);
    up_valid = 1'b0;
    tick();                                   // pop 3
    chk("bp_empty", dn_valid, 0);
    chk("bp_stall", stall_cnt, 3);

    // Clear counters.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_stall", stall_cnt, 0);

    // Full-rate streaming of 100 entries.
    up_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      up_data = 35'h4_0000_0000 + 35'(i);
      up_ctrl = 13'(i + 1);
      tick();
      chk("st_data",  dn_data, 64'h4_0000_0000 + 64'(i));
      chk("st_ready", up_ready, 1);
    end
    up_valid = 1'b0;
    tick();
    chk("st_empty", dn_valid, 0);
    chk("st_stall", stall_cnt, 0);

    // Flush while FULL, no accept, no pop.
    up_valid = 1'b1; dn_ready = 1'b0; up_data = 35'h0_0000_00AA; up_ctrl = 13'h0AA;
    tick();
    up_data = 35'h0_0000_00BB; up_ctrl = 13'h0BB;
    tick();
    chk("ff_full_ready", up_ready, 0);
    up_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ff_valid",  dn_valid, 0);
    chk("ff_ctrl",   dn_ctrl, 0);
    chk("ff_ready",  up_ready, 1);
    chk("ff_drop",   drop_cnt, 2);
    chk("ff_stall",  stall_cnt, 2);
    chk("ff_data_clr",  dn_data, 0);
    chk("ff_data_keep", dn_data2, 64'hAA);
    chk("ff_ctrl_keep", dn_ctrl2, 0);

    // Flush in ONE with simultaneous pop and accept.
    up_valid = 1'b1; dn_ready = 1'b1; up_data = 35'h0_0000_00CC; up_ctrl = 13'h0CC;
    tick();
    chk("fo_head_valid", dn_valid, 1);
    chk("fo_head_data",  dn_data, 64'hCC);
    up_data = 35'h0_0000_00DD; up_ctrl = 13'h0DD; flush = 1'b1;
    tick();
    flush = 1'b0; up_valid = 1'b0;
    chk("fo_valid", dn_valid, 0);
    chk("fo_drop",  drop_cnt, 3);
    chk("fo_ready", up_ready, 1);
    chk("fo_data_keep", dn_data2, 64'hCC);
    tick();
    chk("fo_still_empty", dn_valid, 0);

    // Saturation of the 4-bit counter and clear while stalling.
    up_valid = 1'b1; dn_ready = 1'b0; up_data = 35'h0_0000_00EE; up_ctrl = 13'h0EE;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; up_valid = 1'b0;
    chk("sat_start", stall_cnt2, 0);
    repeat (20) tick();
    chk("sat_w4",  stall_cnt2, 15);
    chk("sat_w16", stall_cnt, 20);
    tick();
    chk("sat_hold", stall_cnt2, 15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat_clr",      stall_cnt2, 0);
    chk("sat_clr_drop", drop_cnt, 0);
    tick();
    chk("sat_resume",     stall_cnt2, 1);
    chk("sat_resume_w16", stall_cnt, 1);

    // Asynchronous reset mid-transfer.
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", dn_valid, 0);
    chk("ar_ready", up_ready, 1);
    chk("ar_data",  dn_data, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_drop",  drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
